pretu_2d_stream: RTL and testbench

- Streaming, pipelined 2D RFConv pre-transform across CH parallel channels. Each channel receives a 4x4 input tile and produces Z = Bt·X·B.
- The 1D operator (Eq. 16) is applied along rows as they arrive, then along columns from a tile buffer.
- Input and output use valid/ready handshakes. Ping-pong tile banks let input and output run at the same time.
- The block sits between the line-buffer tile fetcher and the Winograd-domain elementwise multiplier. It replaces the combinational 1D pre-transform.

---
 rtl/pretu_2d_stream.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pretu_2d_stream.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pretu_2d_stream.sv
// Streaming 2D RFConv pre-transform Z = Bt*X*B over CH channels, ping-pong tile banks.
// Optional macro PRETU_SAT_EN: clamp outputs to the signed DW range and add a sticky sat_flag port.
module pretu_2d_stream #(
    parameter int DW = 16,
    parameter int CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*4*DW-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*4*(DW+2)-1:0]   out_data,
    output logic [1:0]               out_row,
    output logic                     out_last,
    output logic                     out_mode
`ifdef PRETU_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int RW   = DW + 1;
    localparam int OW   = DW + 2;
    localparam int ROWW = CH * 4 * RW;
    localparam int OUTW = CH * 4 * OW;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    bank_st_e          bank_st_q   [0:1];
    bank_st_e          bank_st_d   [0:1];
    logic              bank_mode_q [0:1];
    logic              bank_mode_d [0:1];
    logic [ROWW-1:0]   bank_q      [0:1][0:3];
    logic [ROWW-1:0]   bank_d      [0:1][0:3];
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        wr_row_q,  wr_row_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        rd_row_q,  rd_row_d;
    logic              out_bank_q, out_bank_d;
    logic              out_valid_q, out_valid_d;
    logic [OUTW-1:0]   out_data_q,  out_data_d;
    logic [1:0]        out_row_q,   out_row_d;
    logic              out_last_q,  out_last_d;
    logic              out_mode_q,  out_mode_d;
    logic              in_ready_s, in_fire_s, out_fire_s, src_rdy_s, load_s;
    logic [OUTW-1:0]   col_raw_s;

    // Row operator f(a) = [a0-a2, a1+a2, a2-a1, a1-a3], or sign-extension in bypass.
    function automatic logic [ROWW-1:0] row_xform(input logic [CH*4*DW-1:0] d, input logic md);
        logic signed [RW-1:0] a0, a1, a2, a3;
        logic [ROWW-1:0]      res;
        res = '0;
        for (int c = 0; c < CH; c++) begin
            a0 = $signed(d[(c*4+0)*DW +: DW]);
            a1 = $signed(d[(c*4+1)*DW +: DW]);
            a2 = $signed(d[(c*4+2)*DW +: DW]);
            a3 = $signed(d[(c*4+3)*DW +: DW]);
            if (md) begin
                res[(c*4+0)*RW +: RW] = a0 - a2;
                res[(c*4+1)*RW +: RW] = a1 + a2;
                res[(c*4+2)*RW +: RW] = a2 - a1;
                res[(c*4+3)*RW +: RW] = a1 - a3;
            end else begin
                res[(c*4+0)*RW +: RW] = a0;
                res[(c*4+1)*RW +: RW] = a1;
                res[(c*4+2)*RW +: RW] = a2;
                res[(c*4+3)*RW +: RW] = a3;
            end
        end
        return res;
    endfunction

    // Same operator applied down a column; idx selects which output row is produced.
    function automatic logic [OUTW-1:0] col_xform(input logic [ROWW-1:0] r0, input logic [ROWW-1:0] r1,
                                                  input logic [ROWW-1:0] r2, input logic [ROWW-1:0] r3,
                                                  input logic [1:0] idx, input logic md);
        logic signed [OW-1:0] a0, a1, a2, a3, e;
        logic [OUTW-1:0]      res;
        res = '0;
        for (int k = 0; k < CH*4; k++) begin
            a0 = $signed(r0[k*RW +: RW]);
            a1 = $signed(r1[k*RW +: RW]);
            a2 = $signed(r2[k*RW +: RW]);
            a3 = $signed(r3[k*RW +: RW]);
            case (idx)
                2'd0:    e = md ? (a0 - a2) : a0;
                2'd1:    e = md ? (a1 + a2) : a1;
                2'd2:    e = md ? (a2 - a1) : a2;
                2'd3:    e = md ? (a1 - a3) : a3;
                default: e = '0;
            endcase
            res[k*OW +: OW] = e;
        end
        return res;
    endfunction

`ifdef PRETU_SAT_EN
    localparam logic signed [OW-1:0] SAT_MAX = {{3{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_MIN = {{3{1'b1}}, {(DW-1){1'b0}}};
    logic            sat_q, sat_d;
    logic [OUTW-1:0] col_sat_s;
    logic            sat_hit_s;

    // Clamp every element to the DW range and flag any element that was altered.
    always_comb begin
        logic signed [OW-1:0] v;
        col_sat_s = col_raw_s;
        sat_hit_s = 1'b0;
        for (int k = 0; k < CH*4; k++) begin
            v = $signed(col_raw_s[k*OW +: OW]);
            if (v > SAT_MAX) begin
                col_sat_s[k*OW +: OW] = SAT_MAX;
                sat_hit_s = 1'b1;
            end else if (v < SAT_MIN) begin
                col_sat_s[k*OW +: OW] = SAT_MIN;
                sat_hit_s = 1'b1;
            end else begin
                col_sat_s[k*OW +: OW] = v;
            end
        end
    end
`endif

    assign in_ready_s = (bank_st_q[wr_bank_q] == BANK_EMPTY) || (bank_st_q[wr_bank_q] == BANK_FILLING);
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = out_valid_q && out_ready;
    // Row 0 only needs R0/R2, so it may be loaded in the same cycle the tile's row 3 arrives.
    assign src_rdy_s  = (bank_st_q[rd_bank_q] == BANK_FULL) || (bank_st_q[rd_bank_q] == BANK_DRAINING) ||
                        ((rd_row_q == 2'd0) && in_fire_s && (wr_row_q == 2'd3) && (wr_bank_q == rd_bank_q));
    assign load_s     = ((!out_valid_q) || out_ready) && src_rdy_s;
    assign col_raw_s  = col_xform(bank_q[rd_bank_q][0], bank_q[rd_bank_q][1], bank_q[rd_bank_q][2],
                                  bank_q[rd_bank_q][3], rd_row_q, bank_mode_q[rd_bank_q]);

    // Next-state: write side, per-bank FSM and output register load.
    always_comb begin
        bank_st_d   = bank_st_q;
        bank_mode_d = bank_mode_q;
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        wr_row_d    = wr_row_q;
        rd_bank_d   = rd_bank_q;
        rd_row_d    = rd_row_q;
        out_bank_d  = out_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        out_mode_d  = out_mode_q;
`ifdef PRETU_SAT_EN
        sat_d       = sat_q;
`endif
        if (in_fire_s) begin
            bank_d[wr_bank_q][wr_row_q] = row_xform(in_data, (wr_row_q == 2'd0) ? mode_i : bank_mode_q[wr_bank_q]);
            if (wr_row_q == 2'd0) begin
                bank_mode_d[wr_bank_q] = mode_i;
                bank_st_d[wr_bank_q]   = BANK_FILLING;
            end else if (wr_row_q == 2'd3) begin
                bank_st_d[wr_bank_q]   = BANK_FULL;
            end else begin
                bank_st_d[wr_bank_q]   = bank_st_q[wr_bank_q];
            end
            if (wr_row_q == 2'd3) begin
                wr_bank_d = ~wr_bank_q;
                wr_row_d  = 2'd0;
            end else begin
                wr_row_d  = wr_row_q + 2'd1;
            end
        end else begin
            wr_row_d = wr_row_q;
        end

        // The draining bank is never the bank being written, so these updates cannot collide.
        if (out_fire_s) begin
            if (out_last_q) begin
                bank_st_d[out_bank_q] = BANK_EMPTY;
            end else if (out_row_q == 2'd0) begin
                bank_st_d[out_bank_q] = BANK_DRAINING;
            end else begin
                bank_st_d[out_bank_q] = bank_st_q[out_bank_q];
            end
        end else begin
            out_bank_d = out_bank_q;
        end

        if (load_s) begin
            out_valid_d = 1'b1;
`ifdef PRETU_SAT_EN
            out_data_d  = col_sat_s;
            sat_d       = sat_q | sat_hit_s;
`else
            out_data_d  = col_raw_s;
`endif
            out_row_d   = rd_row_q;
            out_last_d  = (rd_row_q == 2'd3);
            out_mode_d  = bank_mode_q[rd_bank_q];
            out_bank_d  = rd_bank_q;
            rd_row_d    = rd_row_q + 2'd1;
            if (rd_row_q == 2'd3) begin
                rd_bank_d = ~rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any partial or pending tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b]   <= BANK_EMPTY;
                bank_mode_q[b] <= 1'b0;
                for (int r = 0; r < 4; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
            wr_bank_q   <= 1'b0;
            wr_row_q    <= 2'd0;
            rd_bank_q   <= 1'b0;
            rd_row_q    <= 2'd0;
            out_bank_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= 2'd0;
            out_last_q  <= 1'b0;
            out_mode_q  <= 1'b0;
`ifdef PRETU_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            bank_st_q   <= bank_st_d;
            bank_mode_q <= bank_mode_d;
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            rd_bank_q   <= rd_bank_d;
            rd_row_q    <= rd_row_d;
            out_bank_q  <= out_bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            out_mode_q  <= out_mode_d;
`ifdef PRETU_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign out_mode  = out_mode_q;
`ifdef PRETU_SAT_EN
    assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_pretu_2d_stream.sv
// Self-checking bench for pretu_2d_stream: table vectors, a reference 2D model and a scoreboard queue.
module tb_pretu_2d_stream;

    localparam int DW  = 16;
    localparam int CH  = 4;
    localparam int OW  = DW + 2;
    localparam int IW  = CH * 4 * DW;
    localparam int OWW = CH * 4 * OW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_i = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_last, out_mode;
    logic [IW-1:0]  in_data = '0;
    logic [OWW-1:0] out_data;
    logic [1:0]     out_row;
`ifdef PRETU_SAT_EN
    logic sat_flag;
`endif

    pretu_2d_stream #(.DW(DW), .CH(CH)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .out_mode(out_mode)
`ifdef PRETU_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                   mode;
        logic                   flip;
        logic [3:0][3:0][31:0]  x;
        logic [3:0][3:0][31:0]  z;
    } vec_t;

    typedef struct packed {
        logic [OWW-1:0] data;
        logic [1:0]     row;
        logic           last;
        logic           mode;
    } exp_t;

    vec_t vecs [3];
    exp_t sbq [$];
    int   cur  [CH][4][4];
    int   zall [CH][4][4];
    int   n_chk = 0;
    int   n_fail = 0;
    int   beats = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   cyc = 0;

    task automatic chk(input string name, input logic [OWW-1:0] act, input logic [OWW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_model(input int v);
`ifdef PRETU_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
`endif
        return v;
    endfunction

    // Reference Z = Bt*X*B per channel, built from the 1D operator applied to rows then columns.
    task automatic model_all(input bit mode);
        int t [4][4];
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[r][0] = mode ? cur[c][r][0] - cur[c][r][2] : cur[c][r][0];
                t[r][1] = mode ? cur[c][r][1] + cur[c][r][2] : cur[c][r][1];
                t[r][2] = mode ? cur[c][r][2] - cur[c][r][1] : cur[c][r][2];
                t[r][3] = mode ? cur[c][r][1] - cur[c][r][3] : cur[c][r][3];
            end
            for (int j = 0; j < 4; j++) begin
                zall[c][0][j] = sat_model(mode ? t[0][j] - t[2][j] : t[0][j]);
                zall[c][1][j] = sat_model(mode ? t[1][j] + t[2][j] : t[1][j]);
                zall[c][2][j] = sat_model(mode ? t[2][j] - t[1][j] : t[2][j]);
                zall[c][3][j] = sat_model(mode ? t[1][j] - t[3][j] : t[3][j]);
            end
        end
    endtask

    task automatic fill_rand(input int lim);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    cur[c][r][j] = int'($urandom_range(0, 2 * lim)) - lim;
    endtask

    // Queue the four expected rows of the tile in cur; channel 0 may come from a table vector.
    task automatic push_exp(input bit mode, input int v);
        exp_t e;
        logic signed [31:0] t;
        model_all(mode);
        if (v >= 0) begin
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    zall[0][r][j] = $signed(vecs[v].z[r][j]);
        end
        for (int r = 0; r < 4; r++) begin
            e.data = '0;
            for (int c = 0; c < CH; c++)
                for (int j = 0; j < 4; j++) begin
                    t = zall[c][r][j];
                    e.data[(c*4+j)*OW +: OW] = t[OW-1:0];
                end
            e.row  = 2'(r);
            e.last = (r == 3);
            e.mode = mode;
            sbq.push_back(e);
        end
    endtask

    task automatic send_cur(input bit mode, input bit flip, input int nrows, output int stalls);
        logic signed [31:0] t;
        bit ok;
        int waited;
        stalls = 0;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < CH; c++)
                for (int j = 0; j < 4; j++) begin
                    t = cur[c][r][j];
                    in_data[(c*4+j)*DW +: DW] = t[DW-1:0];
                end
            mode_i   = (flip && r == 2) ? ~mode : mode;
            in_valid = 1'b1;
            ok = 1'b0;
            waited = 0;
            while (!ok) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                if (!ok) begin
                    stalls++;
                    waited++;
                    if (waited > 300) begin
                        chk("in_ready_timeout", 1'b0, 1'b1);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", (n < 300), 1'b1);
    endtask

    task automatic load_vec(input int v);
        fill_rand(1000);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                cur[0][r][j] = $signed(vecs[v].x[r][j]);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_out_row"}, out_row, 2'd0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_out_mode"}, out_mode, 1'b0);
    endtask

    initial begin
        int st, st_tot;
        vec_t v;
        exp_t e;
        bit hold_v;
        logic [OWW+3:0] hold_s;

        // Vector table: basic RFConv tile, bypass with a mode toggle on row 2, width extremes.
        v = '0; v.mode = 1'b1; v.flip = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) v.x[r][j] = 32'(r * 4 + j + 1);
        v.z[0] = {32'sd0, 32'sd0, -32'sd16, 32'sd0};
        v.z[1] = {-32'sd4, 32'sd2, 32'sd34, -32'sd4};
        v.z[2] = {32'sd0, 32'sd0, 32'sd8, 32'sd0};
        v.z[3] = {32'sd0, 32'sd0, -32'sd16, 32'sd0};
        vecs[0] = v;
        v.mode = 1'b0; v.flip = 1'b1;
        v.z = v.x;
        vecs[1] = v;
        v = '0; v.mode = 1'b1;
        v.x[1] = {-32'sd32768, 32'sd0, 32'sd32767, 32'sd0};
        v.x[3] = {32'sd32767, 32'sd0, -32'sd32768, 32'sd0};
`ifdef PRETU_SAT_EN
        v.z[1] = {32'sd32767, -32'sd32767, 32'sd32767, 32'sd0};
        v.z[2] = {-32'sd32768, 32'sd32767, -32'sd32767, 32'sd0};
        v.z[3] = {32'sd32767, -32'sd32768, 32'sd32767, 32'sd0};
`else
        v.z[1] = {32'sd65535, -32'sd32767, 32'sd32767, 32'sd0};
        v.z[2] = {-32'sd65535, 32'sd32767, -32'sd32767, 32'sd0};
        v.z[3] = {32'sd131070, -32'sd65535, 32'sd65535, 32'sd0};
`endif
        vecs[2] = v;

        // Output monitor: scoreboard pop on every transfer plus hold-stability under backpressure.
        hold_v = 1'b0;
        hold_s = '0;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    hold_v = 1'b0;
                end else begin
                    if (hold_v) begin
                        chk("hold_valid", out_valid, 1'b1);
                        chk("hold_stable", {out_data, out_row, out_last, out_mode}, hold_s);
                    end
                    if (out_valid && out_ready) begin
                        beats++;
                        if (first_cyc < 0) first_cyc = cyc;
                        last_cyc = cyc;
                        if (sbq.size() == 0) begin
                            chk("unexpected_beat", out_valid, 1'b0);
                        end else begin
                            e = sbq.pop_front();
                            chk("out_data", out_data, e.data);
                            chk("out_row", out_row, e.row);
                            chk("out_last", out_last, e.last);
                            chk("out_mode", out_mode, e.mode);
                        end
                    end
                    hold_v = out_valid && !out_ready;
                    hold_s = {out_data, out_row, out_last, out_mode};
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        chk("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
`ifdef PRETU_SAT_EN
            if (i == 2) chk("sat_flag_clear", sat_flag, 1'b0);
`endif
            load_vec(i);
            push_exp(vecs[i].mode, i);
            send_cur(vecs[i].mode, vecs[i].flip, 4, st);
            in_valid = 1'b0;
            chk("first_latency_valid", out_valid, 1'b1);
            chk("first_latency_row", out_row, 2'd0);
            wait_drain();
        end
`ifdef PRETU_SAT_EN
        chk("sat_flag_set", sat_flag, 1'b1);
`endif

        // Back-to-back: 8 tiles with in_valid and out_ready held high.
        beats = 0; first_cyc = -1; st_tot = 0;
        for (int t = 0; t < 8; t++) begin
            fill_rand(32767);
            push_exp(t[0], -1);
            send_cur(t[0], 1'b0, 4, st);
            st_tot += st;
        end
        in_valid = 1'b0;
        wait_drain();
        chk("b2b_stalls", 32'(st_tot), 32'd0);
        chk("b2b_beats", 32'(beats), 32'd32);
        chk("b2b_contiguous", 32'(last_cyc - first_cyc), 32'd31);

        // Backpressure: two tiles fill both banks, the third waits until a bank frees.
        out_ready = 1'b0;
        st_tot = 0;
        for (int t = 0; t < 2; t++) begin
            fill_rand(20000);
            push_exp(1'b1, -1);
            send_cur(1'b1, 1'b0, 4, st);
            st_tot += st;
        end
        in_valid = 1'b0;
        chk("bp_first_8_no_stall", 32'(st_tot), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        fork
            begin
                fill_rand(20000);
                push_exp(1'b0, -1);
                send_cur(1'b0, 1'b0, 4, st);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_third_stalled", (st >= 5), 1'b1);
        wait_drain();

        // Reset after two rows of a tile.
        fill_rand(5000);
        send_cur(1'b1, 1'b0, 2, st);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid_tile");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", in_ready, 1'b1);
`ifdef PRETU_SAT_EN
        chk("rst_sat_flag", sat_flag, 1'b0);
`endif
        load_vec(0);
        push_exp(1'b1, 0);
        send_cur(1'b1, 1'b0, 4, st);
        in_valid = 1'b0;
        wait_drain();

        // Reset while a tile is waiting to drain; its rows must never appear.
        out_ready = 1'b0;
        fill_rand(5000);
        push_exp(1'b1, -1);
        send_cur(1'b1, 1'b0, 4, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check_zero_outputs("rst_drain");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_drain_no_stale", out_valid, 1'b0);
        load_vec(1);
        push_exp(1'b0, 1);
        send_cur(1'b0, 1'b1, 4, st);
        in_valid = 1'b0;
        wait_drain();
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
